// File: rtl/bcd_freq_entry.sv
// bcd_freq_entry: turns a 4-digit BCD frequency setting into the binary
// phase-increment word for the DDS accumulator. The conversion is sequential:
// each cycle applies one Horner step, acc = acc*10 + digit. A load/busy/done
// handshake controls it, and the block checks each digit and the final range.
module bcd_freq_entry #(
    parameter int unsigned CTL_W     = 12,
    parameter int unsigned CTL_MAX   = 4095,
    parameter int unsigned RESET_CTL = 100
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [3:0]       thou,
    input  logic [3:0]       hund,
    input  logic [3:0]       ten,
    input  logic [3:0]       one,
    output logic [CTL_W-1:0] freq_ctl,
    output logic             busy,
    output logic             done,
    output logic [1:0]       err
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] CHECK  = 2'd1;
    localparam logic [1:0] MAC    = 2'd2;
    localparam logic [1:0] COMMIT = 2'd3;

    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_DIGIT = 2'b01;
    localparam logic [1:0] ERR_OVF   = 2'b10;

    logic [1:0]       state_q, state_d;
    // Latched digits: [3] thousands, [2] hundreds, [1] tens, [0] ones.
    logic [3:0][3:0]  dig_q, dig_d;
    logic [1:0]       idx_q, idx_d;
    // 14 bits holds 9999, so the multiply-accumulate never wraps.
    logic [13:0]      acc_q, acc_d;
    logic             invalid_q, invalid_d;
    logic [CTL_W-1:0] freq_q, freq_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [1:0]       err_q, err_d;
    logic             digit_bad;

    // Flag any latched digit outside 0..9.
    always_comb begin
        digit_bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (dig_q[i] > 4'd9) begin
                digit_bad = 1'b1;
            end
        end
    end

    // Next-state logic for the IDLE -> CHECK -> MAC x4 -> COMMIT sequence.
    always_comb begin
        state_d   = state_q;
        dig_d     = dig_q;
        idx_d     = idx_q;
        acc_d     = acc_q;
        invalid_d = invalid_q;
        freq_d    = freq_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = err_q;
        case (state_q)
            IDLE: begin
                if (load) begin
                    dig_d     = {thou, hund, ten, one};
                    acc_d     = '0;
                    invalid_d = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = CHECK;
                end
            end
            CHECK: begin
                if (digit_bad) begin
                    invalid_d = 1'b1;
                    state_d   = COMMIT;
                end else begin
                    idx_d   = 2'd3;
                    state_d = MAC;
                end
            end
            MAC: begin
                acc_d = (acc_q << 3) + (acc_q << 1) + {10'd0, dig_q[idx_q]};
                if (idx_q == 2'd0) begin
                    state_d = COMMIT;
                end else begin
                    idx_d = idx_q - 2'd1;
                end
            end
            COMMIT: begin
                if (invalid_q) begin
                    err_d = ERR_DIGIT;
                end else if (32'(acc_q) > CTL_MAX) begin
                    freq_d = CTL_W'(CTL_MAX);
                    err_d  = ERR_OVF;
                end else begin
                    freq_d = CTL_W'(acc_q);
                    err_d  = ERR_OK;
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers. Async reset discards any conversion in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            dig_q     <= '0;
            idx_q     <= '0;
            acc_q     <= '0;
            invalid_q <= 1'b0;
            freq_q    <= CTL_W'(RESET_CTL);
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= ERR_OK;
        end else begin
            state_q   <= state_d;
            dig_q     <= dig_d;
            idx_q     <= idx_d;
            acc_q     <= acc_d;
            invalid_q <= invalid_d;
            freq_q    <= freq_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign freq_ctl = freq_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_bcd_freq_entry.sv
// Testbench for bcd_freq_entry. The reference model computes the expected
// word with decimal arithmetic on the four digits.
module tb_bcd_freq_entry;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [3:0]  thou = '0, hund = '0, ten = '0, one = '0;
    logic [11:0] freq_ctl;
    logic        busy, done;
    logic [1:0]  err;

    int passed = 0;
    int total  = 0;

    // Reference model state
    int exp_freq = 100;
    int exp_err  = 0;

    bcd_freq_entry dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .thou     (thou),
        .hund     (hund),
        .ten      (ten),
        .one      (one),
        .freq_ctl (freq_ctl),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    endtask

    // Reference model: update expected freq/err; return expected latency.
    task automatic model(input int th, input int hu, input int te, input int on,
                         output int lat);
        int val;
        if (th > 9 || hu > 9 || te > 9 || on > 9) begin
            exp_err = 1;
            lat     = 2;
        end else begin
            val = th * 1000 + hu * 100 + te * 10 + on;
            if (val > 4095) begin
                exp_freq = 4095;
                exp_err  = 2;
            end else begin
                exp_freq = val;
                exp_err  = 0;
            end
            lat = 6;
        end
    endtask

    // One load pulse; check latency, busy length, stability, result, done width.
    task automatic conv(input string tag, input int th, input int hu, input int te,
                        input int on);
        int lat_exp, lat, busy_cnt, old_freq;
        bit stable;
        old_freq = exp_freq;
        model(th, hu, te, on, lat_exp);
        @(negedge clk);
        thou = 4'(th); hund = 4'(hu); ten = 4'(te); one = 4'(on);
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        // Later input changes must be ignored.
        thou = 4'($urandom); hund = 4'($urandom); ten = 4'($urandom); one = 4'($urandom);
        lat = 0;
        busy_cnt = 0;
        stable = 1'b1;
        while (!done && lat < 20) begin
            if (busy) busy_cnt++;
            if (freq_ctl !== 12'(old_freq)) stable = 1'b0;
            @(negedge clk);
            lat++;
        end
        chk({tag, " latency"}, lat, lat_exp);
        chk({tag, " busy_cycles"}, busy_cnt, lat_exp);
        chk({tag, " freq_stable"}, 32'(stable), 1);
        chk({tag, " freq_ctl"}, freq_ctl, exp_freq);
        chk({tag, " err"}, err, exp_err);
        chk({tag, " busy_at_done"}, busy, 0);
        @(negedge clk);
        chk({tag, " done_width"}, done, 0);
    endtask

    initial begin
        int n_done, gap, th, hu, te, on;

        // 1 Reset state
        #12;
        chk("reset freq_ctl", freq_ctl, 100);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset err", err, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 2 Basic conversion
        conv("c0100", 0, 1, 0, 0);

        // 3 Range edges
        conv("c4095", 4, 0, 9, 5);
        conv("c4096", 4, 0, 9, 6);
        conv("c9999", 9, 9, 9, 9);
        conv("c0000", 0, 0, 0, 0);

        // 4 Invalid digit keeps previous value, next valid clears err
        conv("c1234", 1, 2, 3, 4);
        conv("inval", 1, 10, 3, 4);
        conv("c0777", 0, 7, 7, 7);

        // 5 load and digit changes mid-conversion are ignored
        @(negedge clk);
        thou = 4'd1; hund = 4'd2; ten = 4'd3; one = 4'd4;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        thou = 4'd9; hund = 4'd9; ten = 4'd9; one = 4'd9;
        n_done = 0;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            if (i == 1) load = 1'b1;
            if (i == 2) load = 1'b0;
            if (done) begin
                n_done++;
                chk("mid_load freq_ctl", freq_ctl, 1234);
                chk("mid_load err", err, 0);
            end
        end
        chk("mid_load done_pulses", n_done, 1);
        exp_freq = 1234;
        exp_err  = 0;

        // 6 Async reset mid-conversion
        @(negedge clk);
        thou = 4'd2; hund = 4'd0; ten = 4'd0; one = 4'd0;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst freq_ctl", freq_ctl, 100);
        chk("async_rst busy", busy, 0);
        chk("async_rst done", done, 0);
        chk("async_rst err", err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_freq = 100;
        exp_err  = 0;
        repeat (8) @(negedge clk);
        chk("post_rst idle busy", busy, 0);
        chk("post_rst idle done", done, 0);
        chk("post_rst freq_ctl", freq_ctl, 100);
        conv("c2000", 2, 0, 0, 0);

        // Load held high: back-to-back conversions every 7 cycles
        @(negedge clk);
        thou = 4'd0; hund = 4'd0; ten = 4'd5; one = 4'd0;
        load = 1'b1;
        gap = 0;
        while (!done && gap < 20) begin
            @(negedge clk);
            gap++;
        end
        chk("held first_latency", gap, 7);
        gap = 0;
        @(negedge clk);
        gap++;
        while (!done && gap < 20) begin
            @(negedge clk);
            gap++;
        end
        load = 1'b0;
        chk("held period", gap, 7);
        chk("held freq_ctl", freq_ctl, 50);
        exp_freq = 50;
        exp_err  = 0;
        @(negedge clk);
        @(negedge clk);
        chk("held stops busy", busy, 0);

        // Randomized conversions against the model
        for (int k = 0; k < 25; k++) begin
            th = int'($urandom_range(0, 9));
            hu = int'($urandom_range(0, 9));
            te = int'($urandom_range(0, 9));
            on = int'($urandom_range(0, 9));
            if ($urandom_range(0, 5) == 0) begin
                case ($urandom_range(0, 3))
                    0: th = int'($urandom_range(10, 15));
                    1: hu = int'($urandom_range(10, 15));
                    2: te = int'($urandom_range(10, 15));
                    default: on = int'($urandom_range(10, 15));
                endcase
            end
            conv("rand", th, hu, te, on);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
